// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters with sequential init and write-first bypass.
// Optional gshare indexing is enabled by defining BHT_GSHARE_EN.
module bht_sat_predictor #(
  parameter int INDEX_W  = 5,
  parameter int CTR_W    = 2,
  parameter int INIT_CTR = (2**(CTR_W-1))-1
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               en,
  input  logic               lookup_valid,
  input  logic [INDEX_W-1:0] lookup_addr,
  output logic               pred_valid,
  output logic               prediction,
  output logic [CTR_W-1:0]   pred_ctr,
  input  logic               update_valid,
  input  logic [INDEX_W-1:0] update_addr,
  input  logic               update_taken,
  output logic               init_busy
);

  localparam int                 ENTRIES  = 2**INDEX_W;
  localparam logic [CTR_W-1:0]   CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]   CTR_INIT = CTR_W'(INIT_CTR);
  localparam logic [INDEX_W-1:0] IDX_LAST = INDEX_W'(ENTRIES-1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e             state_r;
  logic [INDEX_W-1:0] init_idx_r;
  logic [CTR_W-1:0]   table_r [ENTRIES];

  logic [INDEX_W-1:0] rd_idx_s;
  logic [INDEX_W-1:0] wr_idx_s;
  logic               lookup_ok_s;
  logic               update_ok_s;
  logic [CTR_W-1:0]   new_ctr_s;
  logic [CTR_W-1:0]   rd_ctr_s;

  // Saturating step: never wraps past 0 or CTR_MAX.
  function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] ctr, input logic taken);
    logic [CTR_W-1:0] res;
    if (taken) begin
      res = (ctr == CTR_MAX) ? ctr : ctr + CTR_W'(1);
    end else begin
      res = (ctr == {CTR_W{1'b0}}) ? ctr : ctr - CTR_W'(1);
    end
    return res;
  endfunction

`ifdef BHT_GSHARE_EN
  logic [INDEX_W-1:0] ghr_r;

  // Global history shifts in each accepted outcome.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      ghr_r <= {INDEX_W{1'b0}};
    end else if (update_ok_s) begin
      ghr_r <= {ghr_r[INDEX_W-2:0], update_taken};
    end else begin
      ghr_r <= ghr_r;
    end
  end
`endif

  // Index hashing, acceptance and bypass selection.
  always_comb begin
`ifdef BHT_GSHARE_EN
    rd_idx_s = lookup_addr ^ ghr_r;
    wr_idx_s = update_addr ^ ghr_r;
`else
    rd_idx_s = lookup_addr;
    wr_idx_s = update_addr;
`endif
    lookup_ok_s = (state_r == ST_READY) && en && lookup_valid;
    update_ok_s = (state_r == ST_READY) && en && update_valid;
    new_ctr_s   = sat_step(table_r[wr_idx_s], update_taken);
    if (update_ok_s && (rd_idx_s == wr_idx_s)) begin
      rd_ctr_s = new_ctr_s;
    end else begin
      rd_ctr_s = table_r[rd_idx_s];
    end
  end

  // Init/ready FSM, table writes and registered prediction outputs.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_r    <= ST_INIT;
      init_idx_r <= {INDEX_W{1'b0}};
      pred_valid <= 1'b0;
      prediction <= 1'b0;
      pred_ctr   <= {CTR_W{1'b0}};
      init_busy  <= 1'b1;
    end else begin
      case (state_r)
        ST_INIT: begin
          table_r[init_idx_r] <= CTR_INIT;
          init_idx_r          <= init_idx_r + INDEX_W'(1);
          pred_valid          <= 1'b0;
          if (init_idx_r == IDX_LAST) begin
            state_r   <= ST_READY;
            init_busy <= 1'b0;
          end else begin
            init_busy <= 1'b1;
          end
        end
        ST_READY: begin
          if (update_ok_s) begin
            table_r[wr_idx_s] <= new_ctr_s;
          end
          pred_valid <= lookup_ok_s;
          if (lookup_ok_s) begin
            pred_ctr   <= rd_ctr_s;
            prediction <= rd_ctr_s[CTR_W-1];
          end
          init_busy <= 1'b0;
        end
        default: begin
          state_r    <= ST_INIT;
          init_idx_r <= {INDEX_W{1'b0}};
          pred_valid <= 1'b0;
          init_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bht_sat_predictor.sv
// Directed, table-driven bench for bht_sat_predictor (default and 16x3-bit instances).
module tb_bht_sat_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default instance: 32 entries, 2-bit counters.
  logic       arst_n, en, lv, uv, ut;
  logic [4:0] la, ua;
  logic       pv, pred, busy;
  logic [1:0] ctr;

  bht_sat_predictor dut (
    .clk(clk), .arst_n(arst_n), .en(en),
    .lookup_valid(lv), .lookup_addr(la),
    .pred_valid(pv), .prediction(pred), .pred_ctr(ctr),
    .update_valid(uv), .update_addr(ua), .update_taken(ut),
    .init_busy(busy)
  );

  // Second instance: 16 entries, 3-bit counters.
  logic       arst_n4, en4, lv4, uv4, ut4;
  logic [3:0] la4, ua4;
  logic       pv4, pred4, busy4;
  logic [2:0] ctr4;

  bht_sat_predictor #(.INDEX_W(4), .CTR_W(3)) dut4 (
    .clk(clk), .arst_n(arst_n4), .en(en4),
    .lookup_valid(lv4), .lookup_addr(la4),
    .pred_valid(pv4), .prediction(pred4), .pred_ctr(ctr4),
    .update_valid(uv4), .update_addr(ua4), .update_taken(ut4),
    .init_busy(busy4)
  );

  typedef struct {
    logic       en;
    logic       lv;
    logic [4:0] la;
    logic       uv;
    logic [4:0] ua;
    logic       ut;
    logic       exp_pv;
    logic [1:0] exp_ctr;
    logic       exp_pred;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic l, input logic [4:0] a, input logic u,
                     input logic [4:0] b, input logic t, input logic xpv,
                     input logic [1:0] xc, input logic xp);
    vec_t v;
    v.en = e; v.lv = l; v.la = a; v.uv = u; v.ua = b; v.ut = t;
    v.exp_pv = xpv; v.exp_ctr = xc; v.exp_pred = xp;
    vecs.push_back(v);
  endtask

  task automatic idle();
    en = 1'b1; lv = 1'b0; uv = 1'b0; ut = 1'b0; la = 5'd0; ua = 5'd0;
  endtask

  task automatic lookup(input logic [4:0] a, input logic [1:0] xc, input string name);
    lv = 1'b1; la = a; tick(); lv = 1'b0;
    check({name, "_pv"}, pv, 1);
    check({name, "_ctr"}, ctr, xc);
    check({name, "_pred"}, pred, xc[1]);
  endtask

  // Counts cycles until init_busy drops; also checks no prediction leaks out.
  task automatic wait_init(input int exp_cycles, input string name);
    int n = 0;
    int leaks = 0;
    while (busy && n < 200) begin
      tick();
      n++;
      if (pv) leaks++;
    end
    check({name, "_cycles"}, n, exp_cycles);
    check({name, "_no_pv"}, leaks, 0);
  endtask

  task automatic upd(input logic [4:0] a, input logic t);
    uv = 1'b1; ua = a; ut = t; tick(); uv = 1'b0;
  endtask

  task automatic upd4(input logic [3:0] a, input logic t);
    uv4 = 1'b1; ua4 = a; ut4 = t; tick(); uv4 = 1'b0;
  endtask

  task automatic lookup4(input logic [3:0] a, input logic [2:0] xc, input string name);
    lv4 = 1'b1; la4 = a; tick(); lv4 = 1'b0;
    check({name, "_pv"}, pv4, 1);
    check({name, "_ctr"}, ctr4, xc);
    check({name, "_pred"}, pred4, xc[2]);
  endtask

  initial begin
    idle();
    arst_n = 1'b0;
    arst_n4 = 1'b0; en4 = 1'b1; lv4 = 1'b0; uv4 = 1'b0; ut4 = 1'b0; la4 = 4'd0; ua4 = 4'd0;

    // Reset state.
    tick(); tick();
    check("rst_pv", pv, 0);
    check("rst_pred", pred, 0);
    check("rst_ctr", ctr, 0);
    check("rst_busy", busy, 1);

    // Release; offer an update and lookup on idx 3 throughout init (must be dropped).
    arst_n = 1'b1;
    uv = 1'b1; ua = 5'd3; ut = 1'b1; lv = 1'b1; la = 5'd3;
    wait_init(32, "init");
    idle();

    for (int i = 0; i < 32; i++) lookup(5'(i), 2'b01, $sformatf("init_rd%0d", i));

    // Saturation, bypass, independence, gating, idle hold. Last lookup left 01.
    add(1, 0, 0, 1, 5, 1, 0, 2'b01, 0);
    add(1, 0, 0, 1, 5, 1, 0, 2'b01, 0);
    add(1, 0, 0, 1, 5, 1, 0, 2'b01, 0);
    add(1, 1, 5, 0, 0, 0, 1, 2'b11, 1);
    add(1, 1, 5, 1, 5, 1, 1, 2'b11, 1);
    add(1, 0, 0, 1, 5, 0, 0, 2'b11, 1);
    add(1, 0, 0, 1, 5, 0, 0, 2'b11, 1);
    add(1, 0, 0, 1, 5, 0, 0, 2'b11, 1);
    add(1, 1, 5, 1, 5, 0, 1, 2'b00, 0);
    add(1, 0, 0, 1, 5, 0, 0, 2'b00, 0);
    add(1, 1, 5, 0, 0, 0, 1, 2'b00, 0);
    add(1, 1, 7, 1, 7, 1, 1, 2'b10, 1);
    add(1, 1, 8, 0, 0, 0, 1, 2'b01, 0);
    add(1, 1, 7, 0, 0, 0, 1, 2'b10, 1);
    add(1, 1, 8, 1, 9, 1, 1, 2'b01, 0);
    add(1, 1, 9, 0, 0, 0, 1, 2'b10, 1);
    add(0, 1, 3, 1, 3, 1, 0, 2'b10, 1);
    add(1, 1, 3, 0, 0, 0, 1, 2'b01, 0);
    add(1, 0, 0, 0, 0, 0, 0, 2'b01, 0);

    foreach (vecs[i]) begin
      en = vecs[i].en; lv = vecs[i].lv; la = vecs[i].la;
      uv = vecs[i].uv; ua = vecs[i].ua; ut = vecs[i].ut;
      tick();
      check($sformatf("vec%0d_pv", i), pv, vecs[i].exp_pv);
      check($sformatf("vec%0d_ctr", i), ctr, vecs[i].exp_ctr);
      check($sformatf("vec%0d_pred", i), pred, vecs[i].exp_pred);
    end
    idle();

    // Reset mid-operation after training idx 5 (currently 00) up to 11.
    upd(5, 1); upd(5, 1); upd(5, 1);
    lookup(5, 2'b11, "train5");
    lv = 1'b1; la = 5'd5; arst_n = 1'b0;
    tick();
    check("mrst_pv", pv, 0);
    check("mrst_pred", pred, 0);
    check("mrst_ctr", ctr, 0);
    check("mrst_busy", busy, 1);
    lv = 1'b0; arst_n = 1'b1;
    wait_init(32, "reinit");
    lookup(5, 2'b01, "reinit_rd5");

    // 16-entry, 3-bit instance.
    arst_n4 = 1'b1;
    begin
      int n = 0;
      while (busy4 && n < 200) begin tick(); n++; end
      check("init4_cycles", n, 16);
    end
    lookup4(0, 3'b011, "init4_rd0");
    lookup4(15, 3'b011, "init4_rd15");
    upd4(4'b0010, 1);
    upd4(4'b0011, 1);
`ifdef BHT_GSHARE_EN
    // ghr = 0011: second update landed on entry 0010, lookup 0001 hashes to 0010.
    lookup4(4'b0001, 3'b101, "gshare_rd");
`else
    lookup4(4'b0001, 3'b011, "plain_rd1");
    lookup4(4'b0011, 3'b100, "plain_rd3");
    for (int i = 0; i < 5; i++) upd4(4'd2, 1);
    lookup4(4'd2, 3'b111, "sat4_rd2");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
